// File: rtl/round_sat_pipe_pkg.sv
// Shared definitions for the rounding/saturation pipeline.
// Latency: none (types only). Backpressure: not applicable.
// Contents: the rounding-mode encoding carried with every beat.
package round_sat_pipe_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_TRUNC = 2'd0,  // floor
    MODE_ZERO  = 2'd1,  // toward zero
    MODE_AWAY  = 2'd2,  // half away from zero
    MODE_CONV  = 2'd3   // half to even (convergent)
  } round_mode_e;

endpackage

// File: rtl/round_sat_lane.sv
// One lane of round + saturate; both halves are purely combinational.
// Latency: 0 cycles; the parent registers the round result and the saturate result.
// Backpressure: none here; the parent gates its registers with the pipeline advance.
// Ports:
//   x, mode  -> r, err     rounding half (stage-1 logic), r is BITS_IN-SHIFT+1 bits
//   r_sat    -> y, ovf     saturation half (stage-2 logic), fed from the stage-1 register
module round_sat_lane
  import round_sat_pipe_pkg::*;
#(
  parameter int BITS_IN  = 16,
  parameter int BITS_OUT = 8,
  parameter int SHIFT    = 8
) (
  input  logic [BITS_IN-1:0]    x,
  input  logic [MODE_W-1:0]     mode,
  output logic [BITS_IN-SHIFT:0] r,
  output logic [SHIFT:0]        err,
  input  logic [BITS_IN-SHIFT:0] r_sat,
  output logic [BITS_OUT-1:0]   y,
  output logic                  ovf
);

  localparam int RW = BITS_IN - SHIFT + 1;

  if (SHIFT == 0) begin : g_noshift
    // Nothing is dropped: pass the sample through with one guard bit.
    logic unused_mode;
    assign unused_mode = ^mode;
    assign r   = {x[BITS_IN-1], x};
    assign err = 1'b0;
  end else begin : g_shift
    logic [SHIFT-1:0] f;
    logic [SHIFT-1:0] h;
    logic [RW-1:0]    q;
    logic             inc;

    always_comb begin
      h          = '0;
      h[SHIFT-1] = 1'b1;
      f          = x[SHIFT-1:0];
      // Floor shift, sign-extended by one guard bit so the +1 below cannot wrap.
      q          = {x[BITS_IN-1], x[BITS_IN-1:SHIFT]};
      inc        = 1'b0;
      case (round_mode_e'(mode))
        MODE_TRUNC: inc = 1'b0;
        MODE_ZERO:  inc = x[BITS_IN-1] & (|f);
        MODE_AWAY:  inc = x[BITS_IN-1] ? (f > h) : (f >= h);
        MODE_CONV:  inc = (f > h) | ((f == h) & q[0]);
        default:    inc = 1'b0;
      endcase
    end

    assign r = q + {{(BITS_IN-SHIFT){1'b0}}, inc};
    // x - (r << SHIFT) reduces to f - inc*2^SHIFT, which always fits SHIFT+1 signed bits.
    assign err = {1'b0, f} - {inc, {SHIFT{1'b0}}};
  end

  // r fits the output when every bit from the output MSB upward equals the sign.
  logic [RW-BITS_OUT:0] r_top;
  logic                 fits;

  assign r_top = r_sat[RW-1:BITS_OUT-1];
  assign fits  = (&r_top) | ~(|r_top);

  always_comb begin
    ovf = ~fits;
    y   = r_sat[BITS_OUT-1:0];
    if (!fits) begin
      if (r_sat[RW-1]) begin
        y             = '0;
        y[BITS_OUT-1] = 1'b1;
      end else begin
        y             = '1;
        y[BITS_OUT-1] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/round_sat_pipe.sv
// Multi-lane round-then-saturate pipeline with residue, per-lane overflow and a sticky overflow count.
// Latency: 2 cycles accept-to-out_valid, 1 beat/clk throughput.
// Backpressure: full valid/ready; in_ready is combinational from out_ready, stalled stages hold.
// Ports:
//   in_valid/in_ready/in_data/in_mode      input beat, NCH lanes packed lane0 in LSBs
//   out_valid/out_ready/out_data/out_err/out_ovf   output beat with residue and overflow flags
//   ovf_clr/ovf_count                      saturating count of output beats with any overflow
module round_sat_pipe
  import round_sat_pipe_pkg::*;
#(
  parameter int BITS_IN  = 16,
  parameter int BITS_OUT = 8,
  parameter int SHIFT    = 8,
  parameter int NCH      = 1,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NCH*BITS_IN-1:0]  in_data,
  input  logic [MODE_W-1:0]       in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NCH*BITS_OUT-1:0] out_data,
  output logic [NCH*(SHIFT+1)-1:0] out_err,
  output logic [NCH-1:0]          out_ovf,
  input  logic                    ovf_clr,
  output logic [CNT_W-1:0]        ovf_count
);

  localparam int RW = BITS_IN - SHIFT + 1;
  localparam int EW = SHIFT + 1;

  logic                     s1_valid;
  logic [NCH*RW-1:0]        s1_r;
  logic [NCH*EW-1:0]        s1_err;
  logic [NCH*RW-1:0]        r_d;
  logic [NCH*EW-1:0]        err_d;
  logic [NCH*BITS_OUT-1:0]  sat_d;
  logic [NCH-1:0]           ovf_d;
  logic                     s1_adv;
  logic                     s2_adv;
  logic                     cnt_hit;

  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    round_sat_lane #(
      .BITS_IN  (BITS_IN),
      .BITS_OUT (BITS_OUT),
      .SHIFT    (SHIFT)
    ) u_lane (
      .x     (in_data[g*BITS_IN +: BITS_IN]),
      .mode  (in_mode),
      .r     (r_d[g*RW +: RW]),
      .err   (err_d[g*EW +: EW]),
      .r_sat (s1_r[g*RW +: RW]),
      .y     (sat_d[g*BITS_OUT +: BITS_OUT]),
      .ovf   (ovf_d[g])
    );
  end

  // Stage 1: rounded value and residue. Data loads only on accept, so a stall holds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
      s1_err   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_r   <= r_d;
        s1_err <= err_d;
      end
    end
  end

  // Stage 2: saturated output; the residue rides along unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= '0;
      out_ovf   <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= sat_d;
        out_err  <= s1_err;
        out_ovf  <= ovf_d;
      end
    end
  end

  assign cnt_hit = out_valid & out_ready & (|out_ovf);

  // A clear that coincides with a counted beat leaves that beat counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (ovf_clr) begin
      ovf_count <= cnt_hit ? CNT_W'(1) : '0;
    end else if (cnt_hit && !(&ovf_count)) begin
      ovf_count <= ovf_count + 1'b1;
    end
  end

endmodule
